// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, control word and decoder.
package cpu_pkg;

    localparam int unsigned CPU_REG_AW = 3;
    localparam int unsigned INSTR_W    = 7 + 3 * CPU_REG_AW;
    localparam int unsigned TOP        = INSTR_W - 1;
    localparam int unsigned OP_LSB     = TOP - 6;
    localparam int unsigned RD_LSB     = 2 * CPU_REG_AW;
    localparam int unsigned RSA_LSB    = CPU_REG_AW;

    typedef struct packed {
        logic                  mb;
        logic                  rw;
        logic                  md;
        logic                  mw;
        logic                  pl;
        logic                  jb;
        logic                  bc;
        logic [3:0]            op_select;
        logic [CPU_REG_AW-1:0] rd;
        logic [CPU_REG_AW-1:0] rsa;
        logic [CPU_REG_AW-1:0] rsb;
    } ctrl_t;

    // Raw instruction to datapath/PC control word.
    function automatic ctrl_t decode_instr(input logic [INSTR_W-1:0] i);
        ctrl_t c;
        c              = '0;
        c.mb           = i[TOP];
        c.rw           = ~i[TOP-1];
        c.md           = i[TOP-2];
        c.mw           = ~i[TOP] & i[TOP-1];
        c.op_select    = i[TOP-3 -: 4];
        // Jump/branch words reuse the low op bit as the branch condition.
        c.op_select[0] = i[OP_LSB] & ~(i[TOP] & i[TOP-1]);
        c.pl           = i[TOP] & i[TOP-1];
        c.jb           = i[TOP-2];
        c.bc           = i[OP_LSB];
        c.rd           = i[RD_LSB  +: CPU_REG_AW];
        c.rsa          = i[RSA_LSB +: CPU_REG_AW];
        c.rsb          = i[0       +: CPU_REG_AW];
        return c;
    endfunction

    // A load writes the register file from memory.
    function automatic logic is_load(input ctrl_t c);
        return c.rw & c.md;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-load scoreboard with same-cycle writeback bypass.
module reg_scoreboard #(
    parameter int unsigned REG_AW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_rd,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_rd,
    output logic [(2**REG_AW)-1:0] eff_c,
    output logic                   busy
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    // Clear first, then set, so a same-cycle set on the same bit wins.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask = NREG'(1) << clr_rd;
        if (set_en) set_mask = NREG'(1) << set_rd;
        eff_c = sb_q & ~clr_mask;
        sb_d  = eff_c | set_mask;
    end

    // Scoreboard bits and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
            busy <= 1'b0;
        end else begin
            sb_q <= sb_d;
            busy <= |sb_d;
        end
    end

endmodule

// File: rtl/instr_dec_stage.sv
// Registered decode stage with valid/ready flow control and load-hazard stalls.
module instr_dec_stage
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = CPU_REG_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7+3*REG_AW-1:0]   in_instr,
    input  logic                    flush,
    input  logic                    wb_valid,
    input  logic [REG_AW-1:0]       wb_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mb,
    output logic                    out_rw,
    output logic                    out_md,
    output logic                    out_mw,
    output logic                    out_pl,
    output logic                    out_jb,
    output logic                    out_bc,
    output logic [3:0]              out_op_select,
    output logic [REG_AW-1:0]       out_rd,
    output logic [REG_AW-1:0]       out_rsa,
    output logic [REG_AW-1:0]       out_rsb,
    output logic                    busy
);

    localparam int unsigned NREG = 2 ** REG_AW;

    ctrl_t           dec_c;
    ctrl_t           ctrl_q;
    logic            out_valid_q;
    logic [NREG-1:0] sb_eff_c;
    logic            xfer_c;
    logic            accept_c;
    logic            held_block_c;
    logic            hazard_c;

    assign dec_c        = decode_instr(in_instr);
    assign xfer_c       = out_valid_q & out_ready;
    assign held_block_c = out_valid_q & ~out_ready & is_load(ctrl_q);

    // RAW/WAW check against pending loads and a stalled load in the output register.
    always_comb begin
        hazard_c = sb_eff_c[dec_c.rsa]
                 | (~dec_c.mb & sb_eff_c[dec_c.rsb])
                 | (dec_c.rw & sb_eff_c[dec_c.rd]);
        if (held_block_c) begin
            hazard_c = hazard_c
                     | (dec_c.rsa == ctrl_q.rd)
                     | (~dec_c.mb & (dec_c.rsb == ctrl_q.rd))
                     | (dec_c.rw & (dec_c.rd == ctrl_q.rd));
        end
    end

    assign in_ready = ~flush & ~hazard_c & (~out_valid_q | out_ready);
    assign accept_c = in_valid & in_ready;

    // Output register: load on accept, drain on handshake or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (accept_c) begin
            ctrl_q      <= dec_c;
            out_valid_q <= 1'b1;
        end else if (xfer_c | flush) begin
            out_valid_q <= 1'b0;
        end
    end

    reg_scoreboard #(
        .REG_AW (REG_AW)
    ) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (xfer_c & is_load(ctrl_q)),
        .set_rd (ctrl_q.rd),
        .clr_en (wb_valid),
        .clr_rd (wb_rd),
        .eff_c  (sb_eff_c),
        .busy   (busy)
    );

    assign out_valid     = out_valid_q;
    assign out_mb        = ctrl_q.mb;
    assign out_rw        = ctrl_q.rw;
    assign out_md        = ctrl_q.md;
    assign out_mw        = ctrl_q.mw;
    assign out_pl        = ctrl_q.pl;
    assign out_jb        = ctrl_q.jb;
    assign out_bc        = ctrl_q.bc;
    assign out_op_select = ctrl_q.op_select;
    assign out_rd        = ctrl_q.rd;
    assign out_rsa       = ctrl_q.rsa;
    assign out_rsb       = ctrl_q.rsb;

endmodule

// File: tb/tb_instr_dec_stage.sv
// Self-checking bench for instr_dec_stage: behavioural model plus directed scenarios.
module tb_instr_dec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        flush;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic        out_mb, out_rw, out_md, out_mw, out_pl, out_jb, out_bc;
    logic [3:0]  out_op_select;
    logic [2:0]  out_rd, out_rsa, out_rsb;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    instr_dec_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mb        (out_mb),
        .out_rw        (out_rw),
        .out_md        (out_md),
        .out_mw        (out_mw),
        .out_pl        (out_pl),
        .out_jb        (out_jb),
        .out_bc        (out_bc),
        .out_op_select (out_op_select),
        .out_rd        (out_rd),
        .out_rsa       (out_rsa),
        .out_rsb       (out_rsb),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    wire [19:0] dut_vec = {out_mb, out_rw, out_md, out_mw, out_pl, out_jb, out_bc,
                           out_op_select, out_rd, out_rsa, out_rsb};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_ov;
    bit        m_have;
    bit [15:0] m_w;
    bit        m_sb [8];
    bit        m_busy;

    function automatic bit [19:0] mdec(input bit [15:0] i);
        bit       mb, rw, md, mw, pl, jb, bc;
        bit [3:0] op;
        mb = i[15];
        rw = !i[14];
        md = i[13];
        mw = !i[15] && i[14];
        pl = i[15] && i[14];
        jb = i[13];
        bc = i[9];
        op = i[12:9];
        if (pl) op[0] = 1'b0;
        return {mb, rw, md, mw, pl, jb, bc, op, i[8:6], i[5:3], i[2:0]};
    endfunction

    function automatic bit m_isload(input bit [15:0] i);
        return !i[14] && i[13];
    endfunction

    function automatic bit m_eff(input int r);
        return m_sb[r] && !(wb_valid && (int'(wb_rd) == r));
    endfunction

    function automatic bit m_rdy();
        bit       mb, rw, hz;
        int       rd, rsa, rsb, hrd;
        mb  = in_instr[15];
        rw  = !in_instr[14];
        rd  = int'(in_instr[8:6]);
        rsa = int'(in_instr[5:3]);
        rsb = int'(in_instr[2:0]);
        hz  = m_eff(rsa) || (!mb && m_eff(rsb)) || (rw && m_eff(rd));
        if (m_ov && !out_ready && m_isload(m_w)) begin
            hrd = int'(m_w[8:6]);
            hz  = hz || (rsa == hrd) || (!mb && rsb == hrd) || (rw && rd == hrd);
        end
        return !flush && !hz && (!m_ov || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov   <= 1'b0;
            m_have <= 1'b0;
            m_w    <= '0;
            m_busy <= 1'b0;
            for (int r = 0; r < 8; r++) m_sb[r] <= 1'b0;
        end else begin : upd
            bit hs, acc, any;
            bit nsb [8];
            hs  = m_ov && out_ready;
            acc = in_valid && m_rdy();
            nsb = m_sb;
            if (wb_valid) nsb[wb_rd] = 1'b0;
            if (hs && m_isload(m_w)) nsb[m_w[8:6]] = 1'b1;
            any = 1'b0;
            for (int r = 0; r < 8; r++) any = any | nsb[r];
            m_sb   <= nsb;
            m_busy <= any;
            if (acc) begin
                m_w    <= in_instr;
                m_ov   <= 1'b1;
                m_have <= 1'b1;
            end else if (hs || flush) begin
                m_ov <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        chk("model_out_valid", 32'(out_valid), 32'(m_ov));
        chk("model_fields", 32'(dut_vec), m_have ? 32'(mdec(m_w)) : 32'd0);
        chk("model_busy", 32'(busy), 32'(m_busy));
        if (in_valid === 1'b1) chk("model_in_ready", 32'(in_ready), 32'(m_rdy()));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] top3, input logic [3:0] op,
                                       input logic [2:0] rd, input logic [2:0] rsa,
                                       input logic [2:0] rsb);
        return {top3, op, rd, rsa, rsb};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fields", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stream three words at full rate.
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h0A4B;
        tick();
        chk("a4b_valid", 32'(out_valid), 32'd1);
        chk("a4b_op", 32'(out_op_select), 32'd5);
        chk("a4b_regs", 32'({out_rd, out_rsa, out_rsb}), 32'({3'd1, 3'd1, 3'd3}));
        chk("a4b_rw_bc", 32'({out_rw, out_bc, out_mb}), 32'b110);
        in_instr = 16'h8011;
        tick();
        chk("8011_op", 32'(out_op_select), 32'd0);
        chk("8011_regs", 32'({out_rd, out_rsa, out_rsb}), 32'({3'd0, 3'd2, 3'd1}));
        chk("8011_mb_rw", 32'({out_mb, out_rw}), 32'b11);
        in_instr = 16'hC248;
        tick();
        chk("c248_pl", 32'(out_pl), 32'd1);
        chk("c248_jb", 32'(out_jb), 32'd0);
        chk("c248_op0", 32'(out_op_select[0]), 32'd0);
        chk("c248_bc", 32'(out_bc), 32'd1);
        chk("c248_rw", 32'(out_rw), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // RAW on a pending load of r3, unblocked by same-cycle writeback.
        in_valid = 1'b1; in_instr = mk(3'b001, 4'h0, 3'd3, 3'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_instr = mk(3'b000, 4'h2, 3'd1, 3'd3, 3'd0);
        #1;
        chk("raw_stall", 32'(in_ready), 32'd0);
        chk("raw_busy_pending", 32'(busy), 32'd1);
        tick();
        tick();
        wb_valid = 1'b1; wb_rd = 3'd3;
        #1;
        chk("raw_wb_bypass", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; wb_valid = 1'b0;
        chk("raw_acc_valid", 32'(out_valid), 32'd1);
        chk("raw_acc_rsa", 32'(out_rsa), 32'd3);
        chk("raw_busy_drop", 32'(busy), 32'd0);
        tick();

        // WAW against a load of r5 held with out_ready low.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(3'b001, 4'h0, 3'd5, 3'd0, 3'd0);
        tick();
        in_instr = mk(3'b000, 4'h1, 3'd5, 3'd0, 3'd0);
        #1;
        chk("waw_stall_held", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        #1;
        chk("waw_stall_sb", 32'(in_ready), 32'd0);
        tick();
        tick();
        wb_valid = 1'b1; wb_rd = 3'd5;
        #1;
        chk("waw_wb", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("waw_acc_rd", 32'(out_rd), 32'd5);
        tick();

        // rsb only matters when mb=0.
        in_valid = 1'b1; in_instr = mk(3'b001, 4'h0, 3'd3, 3'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_instr = mk(3'b100, 4'h0, 3'd0, 3'd0, 3'd3);
        #1;
        chk("mb1_nostall", 32'(in_ready), 32'd1);
        tick();
        in_instr = mk(3'b000, 4'h0, 3'd0, 3'd0, 3'd3);
        #1;
        chk("mb0_stall", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 3'd3;
        tick();
        wb_valid = 1'b0;
        tick();

        // Flush concurrent with a handshaking load of r2.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(3'b001, 4'h0, 3'd2, 3'd0, 3'd0);
        tick();
        out_ready = 1'b1; flush = 1'b1; in_instr = mk(3'b000, 4'h0, 3'd1, 3'd1, 3'd1);
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_xfer_valid", 32'(out_valid), 32'd0);
        chk("flush_xfer_busy", 32'(busy), 32'd1);

        // Flush of a stalled word leaves the scoreboard alone.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(3'b000, 4'h3, 3'd1, 3'd1, 3'd1);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_held_valid", 32'(out_valid), 32'd0);
        chk("flush_keeps_sb", 32'(busy), 32'd1);
        wb_valid = 1'b1; wb_rd = 3'd2;
        tick();
        wb_valid = 1'b0;
        chk("wb2_busy", 32'(busy), 32'd0);

        // Same-cycle set and clear of r4: set wins.
        in_valid = 1'b1; in_instr = mk(3'b001, 4'h0, 3'd4, 3'd0, 3'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 3'd4;
        tick();
        wb_valid = 1'b0;
        chk("setwins_busy", 32'(busy), 32'd1);

        // Reset in the middle of a stall.
        in_valid = 1'b1; in_instr = mk(3'b000, 4'h0, 3'd1, 3'd4, 3'd0);
        #1;
        chk("r4_stall", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_fields", 32'(dut_vec), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_rsa", 32'(out_rsa), 32'd4);
        in_valid = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_dec_stage.md
# instr_dec_stage

Registered, handshaked instruction-decode pipeline stage that generalises the combinational control-word decoder. It accepts a raw instruction from fetch, decodes it into the datapath/PC control word, and holds the result in an output register with valid/ready flow control. A per-register load scoreboard stalls issue on RAW/WAW hazards against outstanding memory loads, and a flush input discards a held instruction after a taken jump/branch.

## Interface
- `REG_AW`, 3: register address width; register file has 2^REG_AW entries.
- `INSTR_W` (localparam), 7+3*REG_AW: instruction width; 16 at default.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage accepts; combinational.
- `in_instr` in INSTR_W: raw instruction.
- `flush` in 1: discard any held, untaken instruction.
- `wb_valid` in 1: a load writeback completes this cycle.
- `wb_rd` in REG_AW: destination of the completing load.
- `out_valid` out 1: decoded control word valid; registered.
- `out_ready` in 1: execute stage accepts.
- `out_mb`, `out_rw`, `out_md`, `out_mw`, `out_pl`, `out_jb`, `out_bc` out 1 each: registered control bits.
- `out_op_select` out 4: EU operation select.
- `out_rd`, `out_rsa`, `out_rsb` out REG_AW each: register fields.
- `busy` out 1: OR of all scoreboard bits.

## Operation
- Field map, with top = INSTR_W-1:
  - mb = i[top]; rw = !i[top-1]; md = i[top-2]; mw = !i[top] & i[top-1].
  - op_select = i[top-3:top-6], with bit 0 ANDed with !(i[top]&i[top-1]).
  - pl = i[top]&i[top-1]; jb = i[top-2]; bc = i[top-6].
  - rd = i[3*REG_AW-1:2*REG_AW]; rsa = i[2*REG_AW-1:REG_AW]; rsb = i[REG_AW-1:0].
- A **load** is a decoded word with rw=1 and md=1.
- Scoreboard: 2^REG_AW bits.
  - Bit rd is set when a load completes the output handshake (out_valid&out_ready).
  - Bit wb_rd is cleared when wb_valid is high.
  - Set and clear on the same bit in the same cycle: set wins.
- Effective scoreboard for the hazard check = sb & ~(wb_valid ? onehot(wb_rd) : 0). A writeback unblocks a stalled instruction in the same cycle.
- **Hazard** is raised when the incoming instruction, decoded, matches any of these:
  - rsa hits the effective scoreboard.
  - mb=0 and rsb hits the effective scoreboard.
  - rw=1 and rd hits the effective scoreboard.
  - Any of the same three checks matches the held output word, when out_valid=1 and the held word is a load not handshaking this cycle.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid&in_ready): the output register loads the decoded word and out_valid is set to 1.
- Handshake without accept: out_valid goes to 0.
- No handshake: the output register holds, and the word stays stable while out_valid=1 & !out_ready.
- flush:
  - Next out_valid=0 unless a new word is accepted; no accept is possible because in_ready=0 during flush.
  - If out_valid&out_ready in the flush cycle, the transfer counts and its scoreboard set applies.
  - Flush never clears scoreboard bits.

## Timing
- Latency 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Full throughput of 1 instruction/cycle when out_ready=1 and there are no hazards.
- in_ready, hazard and the scoreboard bypass are combinational from the inputs; the out_* ports are purely registered.
- Reset, asynchronous assert: out_valid=0, all out_* fields 0, scoreboard all 0, busy=0.
- Reset deassertion mid-stall: the stage restarts empty, and an upstream instruction is re-presented and accepted normally.
- Register index wrap is not applicable: all indices are exactly REG_AW bits.

## Structure
- Package `cpu_pkg`:
  - Field-position localparams as functions of REG_AW.
  - `ctrl_t` packed struct for the control word.
  - Decode function `decode_instr` shared with any remaining combinational decoder users.
- Sub-module `reg_scoreboard`:
  - Parameter REG_AW.
  - Inputs: set_en, set_rd, clr_en, clr_rd.
  - Outputs: effective bit vector and busy.
- The top level holds the output register, hazard compare and handshake logic.

## Test plan
- Reset, then stream 0x0A4B, 0x8011, 0xC248 with out_ready=1 → decoded words appear one per cycle. For 0xC248: pl=1, jb=0, op_select[0]=0, bc=1.
- Load r3 (rw=1, md=1, rd=3) handshakes, then an instruction reading rsa=3 → in_ready=0 until wb_valid with wb_rd=3. It is accepted in that same cycle, and busy drops.
- Back-to-back load r5 held with out_ready=0, next instruction writes rd=5 (WAW) → stall. Release out_ready → the stall persists until wb_rd=5.
- mb=1 instruction with rsb=3 while r3 is pending → no stall. The same instruction with mb=0 → stall.
- Held word with out_ready=0, assert flush → next cycle out_valid=0, in_ready=0 during flush, scoreboard unchanged. Flush concurrent with a handshaking load r2 → bit 2 is set.
- wb_valid rd=4 and a load r4 handshake in the same cycle → bit 4 stays set. Assert rst_n=0 mid-stall → all outputs 0 immediately.
